counter_arbiter: RTL and testbench

//   Shares one WIDTH-bit up-counter among N_REQ requesters, each asking for a timed count of its own length.

---
 rtl/counter_arbiter_pkg.sv | 51 +++++
 rtl/counter_arbiter_count_unit.sv | 46 ++++
 rtl/counter_arbiter.sv | 112 +++++++++++
 tb/tb_counter_arbiter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/counter_arbiter_pkg.sv
// counter_arbiter_pkg
//   Shared types, default sizes and round-robin helpers for counter_arbiter.
//   Contents:
//     arb_state_t    FSM state encoding (IDLE, COUNT, DONE)
//     DEFAULT_*      default N_REQ / WIDTH
//     MAX_REQ        widest request vector the helper functions accept
//     rr_pick        one-hot winner: first set request at/after ptr, wrapping mod n
//     onehot_to_idx  index of the set bit in a one-hot vector
package counter_arbiter_pkg;

    localparam int DEFAULT_N_REQ = 4;
    localparam int DEFAULT_WIDTH = 4;
    localparam int MAX_REQ       = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    // Scans n requesters starting at ptr; the first set request wins.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                   input int ptr,
                                                   input int n);
        logic [MAX_REQ-1:0] oh;
        logic               found;
        int                 idx;
        oh    = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (i < n && !found) begin
                idx = (ptr + i) % n;
                if (req[idx]) begin
                    oh[idx] = 1'b1;
                    found   = 1'b1;
                end
            end
        end
        return oh;
    endfunction

    function automatic int onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/counter_arbiter_count_unit.sv
// arb_count_unit
//   WIDTH-bit up-counter with synchronous clear, count enable, and a loadable
//   limit register; at_limit flags count == limit.
//   Ports:
//     clk       in   clock, posedge
//     reset     in   synchronous active-low reset
//     clear     in   force count to 0 (wins over enable)
//     load      in   capture limit_in into the limit register
//     enable    in   increment count by 1
//     limit_in  in   WIDTH  new limit
//     count     out  WIDTH  current count
//     at_limit  out  count equals the stored limit
module arb_count_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit_in,
    output logic [WIDTH-1:0] count,
    output logic             at_limit
);

    logic [WIDTH-1:0] limit;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            limit <= '0;
        end else begin
            if (load) limit <= limit_in;
            if (clear) begin
                count <= '0;
            end else if (enable) begin
                count <= count + WIDTH'(1);
            end
        end
    end

    assign at_limit = (count == limit);

endmodule

// File: rtl/counter_arbiter.sv
// counter_arbiter
//   Shares one WIDTH-bit up-counter among N_REQ requesters. A round-robin
//   pick chooses the winner, whose length is latched; the FSM clears the
//   counter, counts up to that length, then pulses done for one cycle.
//   Optional build macro: COUNTER_ARB_ABORT_EN -- when defined, dropping the
//   winner's req during COUNT aborts the run (back to IDLE, no done pulse).
//   Ports:
//     clk    in   clock, posedge
//     reset  in   synchronous active-low reset
//     req    in   N_REQ        level request per requester
//     len    in   N_REQ*WIDTH  packed lengths, len[i*WIDTH +: WIDTH] for requester i
//     gnt    out  N_REQ        one-hot grant, zero when not counting
//     busy   out  high while not IDLE
//     done   out  N_REQ        one-cycle one-hot completion pulse
//     count  out  WIDTH        shared counter value
module counter_arbiter
    import counter_arbiter_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] len,
    output logic [N_REQ-1:0]       gnt,
    output logic                   busy,
    output logic [N_REQ-1:0]       done,
    output logic [WIDTH-1:0]       count
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_t         state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   win_idx;
    logic [MAX_REQ-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   next_ptr;
    logic               start;
    logic               abort;
    logic               at_limit;
    logic               cnt_clear;
    logic               cnt_en;

    assign pick_oh  = rr_pick(MAX_REQ'(req), int'(ptr), N_REQ);
    assign pick_idx = IDX_W'(onehot_to_idx(pick_oh));
    assign next_ptr = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + IDX_W'(1);
    assign start    = (state == IDLE) && (|req);

`ifdef COUNTER_ARB_ABORT_EN
    assign abort = (state == COUNT) && !req[win_idx];
`else
    assign abort = 1'b0;
`endif

    // Counter is cleared on grant, on leaving DONE and on abort, so it reads 0 in IDLE.
    assign cnt_clear = start || (state == DONE) || abort;
    assign cnt_en    = (state == COUNT) && !at_limit && !abort;

    arb_count_unit #(.WIDTH(WIDTH)) u_count (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .load     (start),
        .enable   (cnt_en),
        .limit_in (len[int'(pick_idx)*WIDTH +: WIDTH]),
        .count    (count),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            gnt     <= '0;
            done    <= '0;
            ptr     <= '0;
            win_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        gnt     <= pick_oh[N_REQ-1:0];
                        win_idx <= pick_idx;
                        state   <= COUNT;
                    end
                end
                COUNT: begin
                    // Abort outranks reaching the limit in the same cycle.
                    if (abort) begin
                        gnt   <= '0;
                        ptr   <= next_ptr;
                        state <= IDLE;
                    end else if (at_limit) begin
                        done  <= gnt;
                        gnt   <= '0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= '0;
                    ptr   <= next_ptr;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_counter_arbiter.sv
// tb_counter_arbiter
//   Directed bench for counter_arbiter (N_REQ=4, WIDTH=4). Each step drives
//   inputs, pushes the outputs expected after the next posedge onto a
//   scoreboard queue, then pops and compares them 1 ns after that edge.
//   Honors COUNTER_ARB_ABORT_EN for the abort scenario.
module tb_counter_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] len;
    logic [3:0]  gnt;
    logic        busy;
    logic [3:0]  done;
    logic [3:0]  count;

    typedef struct {
        string      tag;
        logic [3:0] gnt;
        logic       busy;
        logic [3:0] done;
        logic [3:0] count;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    counter_arbiter #(.N_REQ(4), .WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len   (len),
        .gnt   (gnt),
        .busy  (busy),
        .done  (done),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive inputs, queue the expectation for the following edge, clock, compare.
    task automatic step(input logic rst, input logic [3:0] r, input logic [15:0] l,
                        input string tag, input logic [3:0] eg, input logic eb,
                        input logic [3:0] ed, input logic [3:0] ec);
        exp_t e;
        reset = rst;
        req   = r;
        len   = l;
        sb.push_back('{tag, eg, eb, ed, ec});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.tag, ".gnt"},   gnt,           e.gnt);
        check({e.tag, ".busy"},  {3'b000, busy}, {3'b000, e.busy});
        check({e.tag, ".done"},  done,          e.done);
        check({e.tag, ".count"}, count,         e.count);
    endtask

    initial begin
        logic [3:0] oh;
        reset = 1'b0;
        req   = '0;
        len   = '0;
        @(negedge clk);

        // 1. Reset held with all requests asserted.
        for (int i = 0; i < 3; i++)
            step(1'b0, 4'b1111, 16'hFFFF, "rst", 4'b0000, 1'b0, 4'b0000, 4'd0);

        // 2. Requester 2, length 3; later len changes must be ignored.
        step(1'b1, 4'b0100, 16'h0300, "r2_grant", 4'b0100, 1'b1, 4'b0000, 4'd0);
        step(1'b1, 4'b0100, 16'h0F00, "r2_c1",    4'b0100, 1'b1, 4'b0000, 4'd1);
        step(1'b1, 4'b0100, 16'h0F00, "r2_c2",    4'b0100, 1'b1, 4'b0000, 4'd2);
        step(1'b1, 4'b0100, 16'h0F00, "r2_c3",    4'b0100, 1'b1, 4'b0000, 4'd3);
        step(1'b1, 4'b0100, 16'h0F00, "r2_done",  4'b0000, 1'b1, 4'b0100, 4'd3);
        step(1'b1, 4'b0000, 16'h0F00, "r2_idle",  4'b0000, 1'b0, 4'b0000, 4'd0);
        step(1'b1, 4'b0000, 16'h0F00, "r2_stay",  4'b0000, 1'b0, 4'b0000, 4'd0);

        // 3. Reset restores pointer 0; all requesters, length 1, round robin.
        step(1'b0, 4'b0000, 16'h1111, "rst2", 4'b0000, 1'b0, 4'b0000, 4'd0);
        oh = 4'b0001;
        for (int g = 0; g < 5; g++) begin
            step(1'b1, 4'b1111, 16'h1111, "rr_grant", oh,      1'b1, 4'b0000, 4'd0);
            step(1'b1, 4'b1111, 16'h1111, "rr_c1",    oh,      1'b1, 4'b0000, 4'd1);
            step(1'b1, 4'b1111, 16'h1111, "rr_done",  4'b0000, 1'b1, oh,      4'd1);
            step(1'b1, 4'b1111, 16'h1111, "rr_idle",  4'b0000, 1'b0, 4'b0000, 4'd0);
            oh = {oh[2:0], oh[3]};
        end
        step(1'b1, 4'b0000, 16'h1111, "rr_quiet", 4'b0000, 1'b0, 4'b0000, 4'd0);

        // 4. Zero length on requester 1 (pointer now 1).
        step(1'b1, 4'b0010, 16'h0000, "l0_grant", 4'b0010, 1'b1, 4'b0000, 4'd0);
        step(1'b1, 4'b0010, 16'h0000, "l0_done",  4'b0000, 1'b1, 4'b0010, 4'd0);
        step(1'b1, 4'b0000, 16'h0000, "l0_idle",  4'b0000, 1'b0, 4'b0000, 4'd0);

        // 5. Reset mid-count: no done pulse, requester 0 wins afterwards.
        step(1'b1, 4'b0001, 16'h0005, "mr_grant", 4'b0001, 1'b1, 4'b0000, 4'd0);
        step(1'b1, 4'b0001, 16'h0005, "mr_c1",    4'b0001, 1'b1, 4'b0000, 4'd1);
        step(1'b1, 4'b0001, 16'h0005, "mr_c2",    4'b0001, 1'b1, 4'b0000, 4'd2);
        step(1'b0, 4'b0001, 16'h0005, "mr_rst",   4'b0000, 1'b0, 4'b0000, 4'd0);
        step(1'b1, 4'b1111, 16'h0000, "mr_first", 4'b0001, 1'b1, 4'b0000, 4'd0);
        step(1'b1, 4'b1111, 16'h0000, "mr_done",  4'b0000, 1'b1, 4'b0001, 4'd0);
        step(1'b1, 4'b0000, 16'h0000, "mr_idle",  4'b0000, 1'b0, 4'b0000, 4'd0);

        // 6. Requester 1 (pointer 1), length 5, req dropped at count 2.
        step(1'b1, 4'b0010, 16'h0050, "ab_grant", 4'b0010, 1'b1, 4'b0000, 4'd0);
        step(1'b1, 4'b0010, 16'h0050, "ab_c1",    4'b0010, 1'b1, 4'b0000, 4'd1);
        step(1'b1, 4'b0010, 16'h0050, "ab_c2",    4'b0010, 1'b1, 4'b0000, 4'd2);
`ifdef COUNTER_ARB_ABORT_EN
        step(1'b1, 4'b0000, 16'h0050, "ab_abort", 4'b0000, 1'b0, 4'b0000, 4'd0);
        step(1'b1, 4'b0000, 16'h0050, "ab_idle",  4'b0000, 1'b0, 4'b0000, 4'd0);
`else
        step(1'b1, 4'b0000, 16'h0050, "ab_c3",    4'b0010, 1'b1, 4'b0000, 4'd3);
        step(1'b1, 4'b0000, 16'h0050, "ab_c4",    4'b0010, 1'b1, 4'b0000, 4'd4);
        step(1'b1, 4'b0000, 16'h0050, "ab_c5",    4'b0010, 1'b1, 4'b0000, 4'd5);
        step(1'b1, 4'b0000, 16'h0050, "ab_hold",  4'b0000, 1'b1, 4'b0010, 4'd5);
        step(1'b1, 4'b0000, 16'h0050, "ab_idle",  4'b0000, 1'b0, 4'b0000, 4'd0);
`endif
        // Pointer is now 2: requesters 0 and 1 asking -> wrap picks 0.
        step(1'b1, 4'b0011, 16'h0000, "ptr_wrap", 4'b0001, 1'b1, 4'b0000, 4'd0);
        step(1'b1, 4'b0011, 16'h0000, "pw_done",  4'b0000, 1'b1, 4'b0001, 4'd0);
        step(1'b1, 4'b0000, 16'h0000, "pw_idle",  4'b0000, 1'b0, 4'b0000, 4'd0);

        n_cmp++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
